if_fetch_queue: RTL and testbench

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue.sv | 108 ++++++++++
 tb/tb_if_fetch_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: issues one memory request at a time and
// buffers the returned words in a small FIFO for the decode stage.
module if_fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 2,
  parameter int RESET_PC = 64,
  parameter logic [XLEN-1:0] NOP = XLEN'(32'h00000013)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            control_j,
  input  logic [XLEN-1:0] pc_j,
  output logic            ins_req,
  output logic [XLEN-1:0] ins_addr,
  input  logic            ins_rvalid,
  input  logic [XLEN-1:0] ins_data,
  input  logic            pipe_ready,
  output logic            pipe_valid,
  output logic [XLEN-1:0] pipe_pc,
  output logic [XLEN-1:0] pipe_pc4,
  output logic [XLEN-1:0] pipe_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [XLEN-1:0] RESET_ADDR = XLEN'(RESET_PC);

  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DROP} state_t;

  state_t            state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   jump_pc;
  logic [XLEN-1:0]   q_pc   [DEPTH];
  logic [XLEN-1:0]   q_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign jump_pc = pc_j & ~XLEN'(3);
  assign empty   = (count == '0);

  // A redirect suppresses the request, the push and the pop of its cycle.
  assign ins_req  = reset_n && (state == IDLE) && (count < FULL_CNT) && !control_j;
  assign ins_addr = fetch_pc;
  assign push     = (state == WAIT) && ins_rvalid && !control_j;
  assign pop      = !empty && pipe_ready && !control_j;

  assign pipe_valid = !empty;
  assign pipe_pc    = empty ? '0  : q_pc[rd_ptr];
  assign pipe_pc4   = empty ? '0  : q_pc[rd_ptr] + XLEN'(4);
  assign pipe_data  = empty ? NOP : q_data[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_ADDR;
    end else begin
      case (state)
        IDLE:      if (ins_req) state <= WAIT;
        WAIT:      if (ins_rvalid) state <= IDLE;
                   else if (control_j) state <= WAIT_DROP;
        WAIT_DROP: if (ins_rvalid) state <= IDLE;
        default:   state <= IDLE;
      endcase
      if (control_j)
        fetch_pc <= jump_pc;
      else if (ins_req)
        fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (control_j) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
    end
  end

  // The fetch PC has already advanced past the outstanding request.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= fetch_pc - XLEN'(4);
      q_data[wr_ptr] <= ins_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: a transaction-level model predicts
// requests and queue contents; a monitor compares the queue head each cycle.
module tb_if_fetch_queue;

  localparam int XLEN = 32;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'd64;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        control_j = 1'b0;
  logic [31:0] pc_j = '0;
  logic        ins_req;
  logic [31:0] ins_addr;
  logic        ins_rvalid = 1'b0;
  logic [31:0] ins_data = '0;
  logic        pipe_ready = 1'b0;
  logic        pipe_valid;
  logic [31:0] pipe_pc;
  logic [31:0] pipe_pc4;
  logic [31:0] pipe_data;

  always #5 clk = ~clk;

  if_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(64), .NOP(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .control_j(control_j), .pc_j(pc_j),
    .ins_req(ins_req), .ins_addr(ins_addr), .ins_rvalid(ins_rvalid),
    .ins_data(ins_data), .pipe_ready(pipe_ready), .pipe_valid(pipe_valid),
    .pipe_pc(pipe_pc), .pipe_pc4(pipe_pc4), .pipe_data(pipe_data)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  // Expected queue contents, oldest first; doubles as the model's occupancy.
  entry_t      sb[$];
  logic [31:0] m_fpc;
  logic [31:0] m_req_pc;
  bit          m_out;
  bit          m_drop;
  int          m_lat;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    if (sb.size() != 0) begin
      check("pipe_valid", 32'(pipe_valid), 32'd1);
      check("pipe_pc", pipe_pc, sb[0].pc);
      check("pipe_pc4", pipe_pc4, sb[0].pc + 32'd4);
      check("pipe_data", pipe_data, sb[0].data);
      if (pipe_ready) void'(sb.pop_front());
    end else begin
      check("pipe_valid_empty", 32'(pipe_valid), 32'd0);
      check("pipe_pc_empty", pipe_pc, 32'd0);
      check("pipe_pc4_empty", pipe_pc4, 32'd0);
      check("pipe_data_empty", pipe_data, NOP);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #3;
      check_output();
    end
  end

  // Runs one cycle starting 1 time unit after a rising edge; the model is
  // advanced at +4, after the monitor has consumed any popped entry.
  task automatic apply_stimulus(input bit cj, input logic [31:0] pcj, input bit rdy,
                                input int lat_max, input bit spurious);
    bit rv;
    bit exp_req;
    control_j  = cj;
    pc_j       = pcj;
    pipe_ready = rdy;
    rv         = m_out ? (m_lat == 0) : spurious;
    ins_rvalid = rv;
    ins_data   = m_out ? mem_word(m_req_pc) : $urandom();
    #1;
    exp_req = !m_out && (sb.size() < DEPTH) && !cj;
    check("ins_req", 32'(ins_req), 32'(exp_req));
    check("ins_addr", ins_addr, m_fpc);
    #2;
    if (m_out && rv) begin
      if (!cj && !m_drop) sb.push_back('{m_req_pc, mem_word(m_req_pc)});
      m_out  = 0;
      m_drop = 0;
    end else if (m_out) begin
      m_lat--;
      if (cj) m_drop = 1;
    end
    if (cj) begin
      sb.delete();
      m_fpc = pcj & ~32'd3;
    end else if (exp_req) begin
      m_out    = 1;
      m_req_pc = m_fpc;
      m_fpc    = m_fpc + 32'd4;
      m_lat    = $urandom_range(0, lat_max);
    end
  endtask

  task automatic step(input bit cj, input logic [31:0] pcj, input bit rdy, input int lat_max);
    @(posedge clk);
    #1;
    apply_stimulus(cj, pcj, rdy, lat_max, 1'b0);
  endtask

  task automatic reset_pulse(input bit at_start);
    if (at_start) #1;
    else begin
      @(posedge clk);
      #1;
    end
    reset_n    = 1'b0;
    control_j  = 1'b0;
    ins_rvalid = 1'b0;
    pipe_ready = 1'b1;
    sb.delete();
    m_fpc  = RESET_PC;
    m_out  = 0;
    m_drop = 0;
    m_lat  = 0;
    #1;
    check("rst_ins_req", 32'(ins_req), 32'd0);
    check("rst_ins_addr", ins_addr, RESET_PC);
    check("rst_pipe_valid", 32'(pipe_valid), 32'd0);
    check("rst_pipe_data", pipe_data, NOP);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    // A stray response right after release must be ignored.
    apply_stimulus(1'b0, 32'd0, 1'b1, 0, 1'b1);
  endtask

  initial begin
    bit          cj;
    bit          rdy;
    logic [31:0] pcj;
    $display("[TB] start");
    reset_pulse(1'b1);
    repeat (20) step(1'b0, 32'd0, 1'b1, 0);

    reset_pulse(1'b0);
    repeat (10) step(1'b0, 32'd0, 1'b0, 0);
    repeat (10) step(1'b0, 32'd0, 1'b1, 0);

    // Redirect while a request is still waiting for its response.
    for (int i = 0; i < 40; i++) begin
      if (m_out && !m_drop && m_lat > 0) begin
        step(1'b1, 32'd68, 1'b1, 1);
        break;
      end
      step(1'b0, 32'd0, 1'b1, 1);
    end
    repeat (8) step(1'b0, 32'd0, 1'b1, 0);

    // Redirect coinciding with a response and a pop.
    for (int i = 0; i < 40; i++) begin
      if (m_out && m_lat == 0 && sb.size() > 0) begin
        step(1'b1, 32'd70, 1'b1, 0);
        break;
      end
      step(1'b0, 32'd0, 1'b0, 0);
    end
    repeat (8) step(1'b0, 32'd0, 1'b1, 0);

    step(1'b1, 32'hFFFFFFFC, 1'b1, 0);
    repeat (8) step(1'b0, 32'd0, 1'b1, 0);

    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        reset_pulse(1'b0);
      end else begin
        cj = ($urandom_range(0, 11) == 0);
        case ($urandom_range(0, 4))
          0:       pcj = $urandom();
          1:       pcj = 32'd70;
          2:       pcj = 32'hFFFFFFFC;
          3:       pcj = 32'hFFFFFFF8;
          default: pcj = 32'd64 + 32'd4 * 32'($urandom_range(0, 15));
        endcase
        if ((i / 100) % 3 == 1) rdy = ($urandom_range(0, 5) == 0);
        else rdy = ($urandom_range(0, 3) != 0);
        step(cj, pcj, rdy, 2);
      end
    end

    @(posedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
